// File: rtl/seg_mmio_pkg.sv
// Register map, reset values, segment glyph table and byte-merge helper shared by the scanner.
// Pure definitions: no latency, no flow control.
package seg_mmio_pkg;

  localparam logic [31:0] DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] CTRL_OFS = 32'h0000_0004;

  localparam int CTRL_MASK_LSB = 0;
  localparam int CTRL_DP_LSB   = 8;
  localparam int CTRL_EN_BIT   = 16;
  localparam int CTRL_BRT_LSB  = 20;

`ifdef SEG_BRIGHTNESS_EN
  localparam logic [31:0] CTRL_RESET = 32'h00F1_00FF;
  localparam logic [31:0] CTRL_WMASK = 32'h00F1_FFFF;
`else
  localparam logic [31:0] CTRL_RESET = 32'h0001_00FF;
  localparam logic [31:0] CTRL_WMASK = 32'h0001_FFFF;
`endif

  // {g,f,e,d,c,b,a}, active low; lowercase glyphs for b and d
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern {g..a}.
// Combinational, zero latency, no flow control.
module hex7seg
  import seg_mmio_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg_mmio_scanner.sv
// 8-digit 7-seg scanner on the picorv32 look-ahead bus; reads return after 1 cycle, writes never stall.
// Optional SEG_BRIGHTNESS_EN adds a 4-bit PWM duty field in CTRL[23:20].
module seg_mmio_scanner
  import seg_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0010,
  parameter int          REFRESH_DIV  = 100000,
  parameter int          BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_la_read,
  input  logic        mem_la_write,
  input  logic [31:0] mem_la_addr,
  input  logic [31:0] mem_la_wdata,
  input  logic [3:0]  mem_la_wstrb,
  output logic        sel_hit,
  output logic [31:0] rdata,
  output logic        frame_tick,
  output logic [7:0]  catodes,
  output logic [7:0]  anodes
);

  localparam int PW = ($clog2(REFRESH_DIV) > 8) ? $clog2(REFRESH_DIV) : 8;
  localparam logic [31:0]   DATA_ADDR = BASE_ADDR + DATA_OFS;
  localparam logic [31:0]   CTRL_ADDR = BASE_ADDR + CTRL_OFS;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

  logic [31:0]   data_sh, data_act, ctrl_sh, ctrl_act;
  logic          pending;
  logic [PW-1:0] presc;
  logic [2:0]    digit;

  logic hit_data, hit_ctrl, wr_data, wr_ctrl, slot_end, wrap;
  logic [7:0] en_mask, dp_mask;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic       duty_ok, lit_ok;

  assign hit_data = (mem_la_addr[31:2] == DATA_ADDR[31:2]);
  assign hit_ctrl = (mem_la_addr[31:2] == CTRL_ADDR[31:2]);
  assign wr_data  = mem_la_write && hit_data;
  assign wr_ctrl  = mem_la_write && hit_ctrl;
  assign slot_end = (presc == PRESC_MAX);
  assign wrap     = slot_end && (digit == 3'd7);

  // Shadow takes bus writes; active only follows at a frame wrap so a frame is never torn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sh  <= '0;
      data_act <= '0;
      ctrl_sh  <= CTRL_RESET;
      ctrl_act <= CTRL_RESET;
      pending  <= 1'b0;
      sel_hit  <= 1'b0;
      rdata    <= '0;
    end else begin
      if (wr_data) data_sh <= byte_merge(data_sh, mem_la_wdata, mem_la_wstrb);
      if (wr_ctrl) ctrl_sh <= byte_merge(ctrl_sh, mem_la_wdata, mem_la_wstrb) & CTRL_WMASK;
      if (wrap && pending) begin
        data_act <= data_sh;
        ctrl_act <= ctrl_sh;
      end
      pending <= wr_data || wr_ctrl || (pending && !wrap);
      sel_hit <= mem_la_read && (hit_data || hit_ctrl);
      if (mem_la_read && hit_data)      rdata <= data_sh;
      else if (mem_la_read && hit_ctrl) rdata <= ctrl_sh;
      else                              rdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc      <= '0;
      digit      <= '0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) digit <= digit + 3'd1;
      frame_tick <= wrap;
    end
  end

  assign en_mask = ctrl_act[CTRL_MASK_LSB +: 8];
  assign dp_mask = ctrl_act[CTRL_DP_LSB +: 8];
  assign cur_nib = data_act[{digit, 2'b00} +: 4];

`ifdef SEG_BRIGHTNESS_EN
  assign duty_ok = (presc[7:4] < ctrl_act[CTRL_BRT_LSB +: 4]);
`else
  assign duty_ok = 1'b1;
`endif

  assign lit_ok = ctrl_act[CTRL_EN_BIT] && en_mask[digit] && duty_ok;

  hex7seg u_hex7seg (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      anodes  <= 8'hFF;
      catodes <= 8'hFF;
    end else if ((presc >= BLANK_END) && lit_ok) begin
      anodes  <= ~(8'd1 << digit);
      catodes <= {~dp_mask[digit], cur_seg};
    end else begin
      anodes  <= 8'hFF;
      catodes <= 8'hFF;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{mem_la_addr[1:0], ctrl_act[31:17]};

endmodule

// File: tb/tb_seg_mmio_scanner.sv
// Scoreboard bench for seg_mmio_scanner: expected slots and read responses are queued by the stimulus,
// and a negedge monitor pops and compares them as the DUT presents lit digits and read data.
`timescale 1ns/1ps
module tb_seg_mmio_scanner;

  localparam int RD = 4;
  localparam int BC = 1;
  localparam logic [31:0] DATA_A   = 32'h1000_0010;
  localparam logic [31:0] CTRL_A   = 32'h1000_0014;
  localparam logic [31:0] CTRL_RST = 32'h0001_00FF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_la_read, mem_la_write;
  logic [31:0] mem_la_addr, mem_la_wdata;
  logic [3:0]  mem_la_wstrb;
  logic        sel_hit, frame_tick;
  logic [31:0] rdata;
  logic [7:0]  catodes, anodes;

  always #5 clk = ~clk;

  seg_mmio_scanner #(
    .BASE_ADDR    (DATA_A),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_la_read  (mem_la_read),
    .mem_la_write (mem_la_write),
    .mem_la_addr  (mem_la_addr),
    .mem_la_wdata (mem_la_wdata),
    .mem_la_wstrb (mem_la_wstrb),
    .sel_hit      (sel_hit),
    .rdata        (rdata),
    .frame_tick   (frame_tick),
    .catodes      (catodes),
    .anodes       (anodes)
  );

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [15:0] scan_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_tick = 0;

  logic [31:0] sh_data, sh_ctrl, act_data, act_ctrl;
  logic        pend;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    sh_data = '0; act_data = '0; sh_ctrl = CTRL_RST; act_ctrl = CTRL_RST; pend = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[31:2] == DATA_A[31:2]) begin
      sh_data = bmerge(sh_data, d, s); pend = 1'b1;
    end else if (a[31:2] == CTRL_A[31:2]) begin
      sh_ctrl = bmerge(sh_ctrl, d, s) & 32'h0001_FFFF; pend = 1'b1;
    end
  endtask

  task automatic boundary();
    if (pend) begin act_data = sh_data; act_ctrl = sh_ctrl; pend = 1'b0; end
  endtask

  task automatic push_frame();
    for (int d = 0; d < 8; d++) begin
      if (act_ctrl[16] && act_ctrl[d])
        scan_q.push_back({~(8'd1 << d), ~act_ctrl[8+d], seg7(act_data[4*d +: 4])});
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_la_write = 1'b1; mem_la_addr = a; mem_la_wdata = d; mem_la_wstrb = s;
    @(posedge clk); #1;
    mem_la_write = 1'b0; mem_la_wstrb = '0; mem_la_addr = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_write(a, d, s);
    model_write(a, d, s);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic h, input logic [31:0] d);
    rd_q.push_back('{hit: h, data: d});
    mem_la_read = 1'b1; mem_la_addr = a;
    @(posedge clk); #1;
    mem_la_read = 1'b0; mem_la_addr = '0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!frame_tick && n < 100);
    check("tick_seen", {31'd0, frame_tick}, 32'd1);
    t_tick = cyc;
  endtask

  task automatic next_frame();
    wait_tick();
    check("frame_drained", scan_q.size(), 0);
    boundary();
    push_frame();
  endtask

  task automatic wait_to(input int off);
    while (cyc < t_tick + off) begin @(posedge clk); #1; end
  endtask

  // Monitor: read responses one cycle after a read, and one queued entry per lit digit slot.
  logic        rd_seen = 1'b0;
  logic        prev_lit = 1'b0;
  logic        have_tick = 1'b0;
  int          lit_cnt = 0;
  int          last_tick = 0;
  logic [15:0] cur_exp = '0;
  rd_exp_t     mon_re;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got sel_hit %b want no response", sel_hit);
      end else begin
        mon_re = rd_q.pop_front();
        check("rd_hit", {31'd0, sel_hit}, {31'd0, mon_re.hit});
        check("rd_data", rdata, mon_re.data);
      end
    end else begin
      check("rd_idle", {31'd0, sel_hit}, 32'd0);
    end
    rd_seen = mem_la_read;

    if (!mon_en) begin
      prev_lit = 1'b0; lit_cnt = 0; have_tick = 1'b0;
    end else begin
      if (anodes != 8'hFF) begin
        if (!prev_lit) begin
          if (scan_q.size() == 0) begin
            total++; bad++;
            $display("FAIL slot_unexpected: got an %h cat %h want dark", anodes, catodes);
          end else begin
            cur_exp = scan_q.pop_front();
            check("slot_an", {24'd0, anodes}, {24'd0, cur_exp[15:8]});
            check("slot_cat", {24'd0, catodes}, {24'd0, cur_exp[7:0]});
          end
          lit_cnt = 1;
        end else begin
          lit_cnt++;
          check("lit_hold", {16'd0, anodes, catodes}, {16'd0, cur_exp});
        end
        prev_lit = 1'b1;
      end else begin
        if (prev_lit) check("lit_len", lit_cnt, RD - BC);
        check("dark_cat", {24'd0, catodes}, 32'h0000_00FF);
        prev_lit = 1'b0;
      end
      if (frame_tick) begin
        if (have_tick) check("tick_period", cyc - last_tick, 32);
        have_tick = 1'b1;
        last_tick = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; mem_la_read = 1'b0; mem_la_write = 1'b0;
    mem_la_addr = '0; mem_la_wdata = '0; mem_la_wstrb = '0;
    repeat (3) @(posedge clk); #1;

    check("rst_anodes", {24'd0, anodes}, 32'h0000_00FF);
    check("rst_catodes", {24'd0, catodes}, 32'h0000_00FF);
    check("rst_sel_hit", {31'd0, sel_hit}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);

    model_reset();
    push_frame();
    mon_en = 1'b1;
    resetn = 1'b1;

    // Register reads after reset, including an unmapped address and ignored low address bits
    bus_read(CTRL_A, 1'b1, CTRL_RST);
    bus_read(32'h1000_0016, 1'b1, CTRL_RST);
    bus_read(DATA_A, 1'b1, 32'd0);
    bus_read(32'h1000_0000, 1'b0, 32'd0);

    // Free-running scan of all zeros
    next_frame();
    next_frame();

    // Mid-frame DATA write only shows after the next wrap
    wait_to(5);
    do_write(DATA_A, 32'h1234_ABCD, 4'hF);
    bus_read(DATA_A, 1'b1, 32'h1234_ABCD);
    next_frame();

    // Write landing in the wrap cycle: active takes the old shadow, new value one frame later
    wait_to(4);
    do_write(DATA_A, 32'h8765_4321, 4'b0011);
    wait_to(31);
    bus_write(DATA_A, 32'h0F0F_5678, 4'hF);
    check("wrap_align", {31'd0, frame_tick}, 32'd1);
    t_tick = cyc;
    check("frame_drained", scan_q.size(), 0);
    boundary();
    model_write(DATA_A, 32'h0F0F_5678, 4'hF);
    push_frame();
    next_frame();

    // Asynchronous reset in the middle of digit 5
    wait_to(22);
    check("pre_reset_an", {24'd0, anodes}, 32'h0000_00DF);
    mon_en = 1'b0;
    scan_q.delete();
    resetn = 1'b0;
    #1;
    check("arst_anodes", {24'd0, anodes}, 32'h0000_00FF);
    check("arst_catodes", {24'd0, catodes}, 32'h0000_00FF);
    check("arst_tick", {31'd0, frame_tick}, 32'd0);
    repeat (3) @(posedge clk); #1;
    model_reset();
    push_frame();
    mon_en = 1'b1;
    resetn = 1'b1;
    next_frame();

    // Partial CTRL writes: mask to digits 0-3, dots on 0 and 2, reserved bits stay 0
    wait_to(2);
    do_write(CTRL_A, 32'h0000_000F, 4'b0001);
    do_write(CTRL_A, 32'h00FF_0000, 4'b0100);
    do_write(CTRL_A, 32'h0000_0500, 4'b0010);
    do_write(32'h1000_0018, 32'hFFFF_FFFF, 4'hF);
    do_write(DATA_A, 32'h0000_9A00, 4'b0010);
    bus_read(CTRL_A, 1'b1, 32'h0001_050F);
    bus_read(DATA_A, 1'b1, 32'h0000_9A00);
    next_frame();
    next_frame();

    wait_tick();
    check("final_drained", scan_q.size(), 0);
    @(posedge clk); #1;
    check("rd_drained", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
